// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and flag bundle for alu_seq
package alu_pkg;
    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_MUL = 6'b000010;
    localparam logic [5:0] FUN_DIV = 6'b000011;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_XOR = 6'b010110;
    localparam logic [5:0] FUN_NOR = 6'b010001;
    localparam logic [5:0] FUN_STA = 6'b011010;
    localparam logic [5:0] FUN_LUI = 6'b011011;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_SRL = 6'b100001;
    localparam logic [5:0] FUN_SRA = 6'b100011;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
    localparam logic [5:0] FUN_NEQ = 6'b110001;
    localparam logic [5:0] FUN_LT  = 6'b110101;
    localparam logic [5:0] FUN_LEZ = 6'b111101;
    localparam logic [5:0] FUN_GEZ = 6'b111001;
    localparam logic [5:0] FUN_GTZ = 6'b111111;
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle between the EX stage and alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             iValid, oReady, iSign, oValid, iReady, oZ, oV, oN, oBusy;
    logic [WIDTH-1:0] iA, iB, oS, oHi;
    logic [5:0]       iALUFun;
    modport slave (input iValid, iA, iB, iALUFun, iSign, iReady,
                   output oReady, oValid, oS, oHi, oZ, oV, oN, oBusy);
    modport master (output iValid, iA, iB, iALUFun, iSign, iReady,
                    input oReady, oValid, oS, oHi, oZ, oV, oN, oBusy);
endinterface

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle ALU ops and flags; unknown opcodes yield zero
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_fun,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_s,
    output flags_t           o_flags
);
    localparam int M = WIDTH - 1;
    logic [WIDTH:0]     w_sum, w_dif;
    logic [SHAMT_W-1:0] w_sh;
    logic               w_add_ov, w_sub_ov, w_lt, w_az;
    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif    = {1'b0, i_a} - {1'b0, i_b};
    assign w_sh     = i_a[SHAMT_W-1:0];
    assign w_add_ov = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
    assign w_sub_ov = (i_a[M] != i_b[M]) && (w_dif[M] != i_a[M]);
    assign w_lt     = i_sign ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
    assign w_az     = i_a == '0;
    always_comb begin
        o_s     = '0;
        o_flags = '0;
        case (i_fun)
            FUN_ADD: begin
                o_s       = w_sum[M:0];
                o_flags.v = i_sign ? w_add_ov : w_sum[WIDTH];
                o_flags.n = i_sign & (w_sum[M] ^ w_add_ov);
            end
            FUN_SUB: begin
                o_s       = w_dif[M:0];
                o_flags.v = i_sign ? w_sub_ov : w_dif[WIDTH];
                o_flags.n = i_sign ? (w_dif[M] ^ w_sub_ov) : w_dif[WIDTH];
            end
            FUN_AND: o_s = i_a & i_b;
            FUN_OR:  o_s = i_a | i_b;
            FUN_XOR: o_s = i_a ^ i_b;
            FUN_NOR: o_s = ~(i_a | i_b);
            FUN_STA: o_s = i_a;
            FUN_SLL: o_s = i_b << w_sh;
            FUN_SRL: o_s = i_b >> w_sh;
            FUN_SRA: o_s = $unsigned($signed(i_b) >>> w_sh);
            FUN_LUI: o_s = {i_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            FUN_EQ:  o_s = {{M{1'b0}}, i_a == i_b};
            FUN_NEQ: o_s = {{M{1'b0}}, i_a != i_b};
            FUN_LT:  o_s = {{M{1'b0}}, w_lt};
            FUN_LEZ: o_s = {{M{1'b0}}, i_a[M] | w_az};
            FUN_GEZ: o_s = {{M{1'b0}}, ~i_a[M]};
            FUN_GTZ: o_s = {{M{1'b0}}, ~i_a[M] & ~w_az};
            default: o_s = '0;
        endcase
        o_flags.z = o_s == '0;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with handshakes, iterative shift-add multiply and
// restoring divide on operand magnitudes with sign fix-up on the final edge.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic      iClk,
    input logic      iRst_n,
    alu_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);
    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_hi, r_lo, r_m, r_s, r_h;
    logic [SHAMT_W:0]   r_cnt;
    logic               r_sign, r_negq, r_negr, r_ovf, r_valid;
    flags_t             r_f, w_c_f, w_f_n;
    logic [WIDTH-1:0]   w_c_s, w_s_n, w_h_n, w_a_mag, w_b_mag, w_hi_n, w_lo_n, w_q, w_r, w_dsub;
    logic [WIDTH:0]     w_madd, w_dsh;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_acc, w_is_mul, w_is_div, w_div0, w_iter, w_last, w_load, w_dok;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_a(bus.iA), .i_b(bus.iB), .i_fun(bus.iALUFun), .i_sign(bus.iSign),
        .o_s(w_c_s), .o_flags(w_c_f)
    );

    assign bus.oReady = (r_state == IDLE) && (!r_valid || bus.iReady);
    assign bus.oBusy  = r_state != IDLE;
    assign bus.oValid = r_valid;
    assign bus.oS     = r_s;
    assign bus.oHi    = r_h;
    assign bus.oZ     = r_f.z;
    assign bus.oV     = r_f.v;
    assign bus.oN     = r_f.n;

    assign w_acc    = bus.iValid && bus.oReady;
    assign w_is_mul = bus.iALUFun == FUN_MUL;
    assign w_is_div = bus.iALUFun == FUN_DIV;
    assign w_div0   = w_is_div && (bus.iB == '0);
    assign w_iter   = w_is_mul || (w_is_div && !w_div0);
    assign w_last   = bus.oBusy && (r_cnt == CNT_ONE);
    assign w_load   = (w_acc && !w_iter) || w_last;
    assign w_a_mag  = (bus.iSign && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    assign w_b_mag  = (bus.iSign && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;

    // One iteration step; the last step feeds the output register directly
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_dsh  = {r_hi, r_lo[WIDTH-1]};
    assign w_dok  = w_dsh >= {1'b0, r_m};
    assign w_dsub = w_dsh[WIDTH-1:0] - r_m;
    assign w_hi_n = (r_state == MUL) ? w_madd[WIDTH:1] : (w_dok ? w_dsub : w_dsh[WIDTH-1:0]);
    assign w_lo_n = (r_state == MUL) ? {w_madd[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_dok};
    assign w_prod = r_negq ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    assign w_q    = r_negq ? -w_lo_n : w_lo_n;
    assign w_r    = r_negr ? -w_hi_n : w_hi_n;

    always_comb begin
        w_state_n = r_state;
        w_s_n     = w_c_s;
        w_h_n     = '0;
        w_f_n     = w_c_f;
        if (r_state == IDLE)
            w_state_n = !w_acc ? IDLE : w_is_mul ? MUL : w_iter ? DIV : IDLE;
        else if (w_last)
            w_state_n = IDLE;
        if (r_state == MUL) begin
            w_s_n   = w_prod[WIDTH-1:0];
            w_h_n   = w_prod[2*WIDTH-1:WIDTH];
            w_f_n.z = w_prod == '0;
            w_f_n.n = r_sign & w_prod[2*WIDTH-1];
            w_f_n.v = r_sign ? (w_h_n != {WIDTH{w_s_n[WIDTH-1]}}) : (w_h_n != '0);
        end else if (r_state == DIV) begin
            w_s_n = w_q;
            w_h_n = w_r;
            w_f_n = '{z: w_q == '0, v: r_ovf, n: r_sign & w_q[WIDTH-1]};
        end else if (w_div0) begin
            w_s_n = '1;
            w_h_n = bus.iA;
            w_f_n = '{z: 1'b0, v: 1'b1, n: bus.iSign};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_s     <= '0;
            r_h     <= '0;
            r_f     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_acc) begin
                r_hi   <= '0;
                r_lo   <= w_is_mul ? w_b_mag : w_a_mag;
                r_m    <= w_is_mul ? w_a_mag : w_b_mag;
                r_cnt  <= CNT_INIT;
                r_sign <= bus.iSign;
                r_negq <= bus.iSign & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
                r_negr <= bus.iSign & bus.iA[WIDTH-1];
                r_ovf  <= bus.iSign && (bus.iA == MIN) && (bus.iB == '1);
            end else if (bus.oBusy) begin
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_load) begin
                r_s     <= w_s_n;
                r_h     <= w_h_n;
                r_f     <= w_f_n;
                r_valid <= 1'b1;
            end else if (bus.iReady) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=32 and WIDTH=16)
module tb_alu_seq;
    import alu_pkg::*;
    typedef struct packed {
        logic [31:0] s;
        logic [31:0] hi;
        logic [2:0]  zvn;
        logic        nc;
    } res_t;
    localparam logic [5:0] FUN_UNK = 6'b000100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    res_t q[$];

    alu_seq_if #(.WIDTH(32)) b32();
    alu_seq_if #(.WIDTH(16)) b16();
    alu_seq #(.WIDTH(32)) u_dut (.iClk(clk), .iRst_n(rst_n), .bus(b32.slave));
    alu_seq #(.WIDTH(16)) u_d16 (.iClk(clk), .iRst_n(rst_n), .bus(b16.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [31:0] s, input logic [31:0] hi, input logic [2:0] zvn, input logic nc);
        return {s, hi, zvn, nc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag);
        res_t e;
        e = q.pop_front();
        chk({tag, ".s"}, b32.oS, e.s);
        chk({tag, ".hi"}, b32.oHi, e.hi);
        chk({tag, ".z"}, 32'(b32.oZ), 32'(e.zvn[2]));
        chk({tag, ".v"}, 32'(b32.oV), 32'(e.zvn[1]));
        if (e.nc) chk({tag, ".n"}, 32'(b32.oN), 32'(e.zvn[0]));
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic sg, input res_t e);
        int n;
        n = 0;
        q.push_back(e);
        b32.iALUFun = f;
        b32.iA      = a;
        b32.iB      = b;
        b32.iSign   = sg;
        b32.iValid  = 1'b1;
        while (!b32.oReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n != 0) chk("accept_wait", 32'(b32.oReady), 32'd1);
        @(negedge clk);
        b32.iValid = 1'b0;
        b32.iA     = $urandom;
        b32.iB     = $urandom;
    endtask

    task automatic recv(input string tag, input int exp_lat, input int exp_busy);
        int lat, busy, rdy;
        lat = 1;
        busy = 0;
        rdy = 0;
        while (!b32.oValid && lat < 200) begin
            busy += int'(b32.oBusy);
            rdy  += int'(b32.oReady);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".busy"}, busy, exp_busy);
        if (exp_busy != 0) chk({tag, ".rdy"}, rdy, 0);
        cmp(tag);
    endtask

    task automatic op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input res_t e, input int lat, input int busy);
        send(f, a, b, sg, e);
        recv(tag, lat, busy);
    endtask

    initial begin
        int seen, lat;
        b32.iValid = 1'b0; b32.iReady = 1'b1; b32.iA = '0; b32.iB = '0; b32.iSign = 1'b0; b32.iALUFun = FUN_ADD;
        b16.iValid = 1'b0; b16.iReady = 1'b1; b16.iA = '0; b16.iB = '0; b16.iSign = 1'b0; b16.iALUFun = FUN_ADD;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.valid", 32'(b32.oValid), 32'd0);
        chk("rst.ready", 32'(b32.oReady), 32'd1);
        chk("rst.busy", 32'(b32.oBusy), 32'd0);
        chk("rst.s", b32.oS, 32'd0);
        chk("rst.hi", b32.oHi, 32'd0);
        chk("rst.zvn", 32'({b32.oZ, b32.oV, b32.oN}), 32'd0);
        // arithmetic flags
        op("add_sov", FUN_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, mk(32'h80000000, 32'h0, 3'b010, 1'b1), 1, 0);
        op("sub_szero", FUN_SUB, 32'h5, 32'h5, 1'b1, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        op("sub_ubor", FUN_SUB, 32'h3, 32'h5, 1'b0, mk(32'hFFFFFFFE, 32'h0, 3'b011, 1'b1), 1, 0);
        op("add_ucar", FUN_ADD, 32'hFFFFFFFF, 32'h2, 1'b0, mk(32'h1, 32'h0, 3'b010, 1'b1), 1, 0);
        op("sub_sov", FUN_SUB, 32'h80000000, 32'h1, 1'b1, mk(32'h7FFFFFFF, 32'h0, 3'b011, 1'b1), 1, 0);
        // logic, shifts, compares
        op("and", FUN_AND, 32'hF0F000FF, 32'h0FF00F0F, 1'b0, mk(32'h00F0000F, 32'h0, 3'b000, 1'b1), 1, 0);
        op("or", FUN_OR, 32'hF0F000FF, 32'h0FF00F0F, 1'b0, mk(32'hFFF00FFF, 32'h0, 3'b000, 1'b1), 1, 0);
        op("xor", FUN_XOR, 32'hF0F000FF, 32'h0FF00F0F, 1'b0, mk(32'hFF000FF0, 32'h0, 3'b000, 1'b1), 1, 0);
        op("nor", FUN_NOR, 32'h0, 32'h0, 1'b0, mk(32'hFFFFFFFF, 32'h0, 3'b000, 1'b1), 1, 0);
        op("sta", FUN_STA, 32'h12345678, 32'hDEADBEEF, 1'b0, mk(32'h12345678, 32'h0, 3'b000, 1'b1), 1, 0);
        op("sll", FUN_SLL, 32'h4, 32'h1, 1'b0, mk(32'h10, 32'h0, 3'b000, 1'b1), 1, 0);
        op("srl", FUN_SRL, 32'h24, 32'h80000000, 1'b0, mk(32'h08000000, 32'h0, 3'b000, 1'b1), 1, 0);
        op("sra", FUN_SRA, 32'h4, 32'h80000000, 1'b0, mk(32'hF8000000, 32'h0, 3'b000, 1'b1), 1, 0);
        op("lui", FUN_LUI, 32'h0, 32'hABCD1234, 1'b0, mk(32'h12340000, 32'h0, 3'b000, 1'b1), 1, 0);
        op("eq", FUN_EQ, 32'h5, 32'h5, 1'b0, mk(32'h1, 32'h0, 3'b000, 1'b1), 1, 0);
        op("neq", FUN_NEQ, 32'h5, 32'h5, 1'b0, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        op("lt_s", FUN_LT, 32'hFFFFFFFF, 32'h1, 1'b1, mk(32'h1, 32'h0, 3'b000, 1'b1), 1, 0);
        op("lt_u", FUN_LT, 32'hFFFFFFFF, 32'h1, 1'b0, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        op("lez", FUN_LEZ, 32'h0, 32'h0, 1'b0, mk(32'h1, 32'h0, 3'b000, 1'b1), 1, 0);
        op("gez", FUN_GEZ, 32'h80000000, 32'h0, 1'b0, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        op("gtz0", FUN_GTZ, 32'h0, 32'h0, 1'b0, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        op("gtz1", FUN_GTZ, 32'h1, 32'h0, 1'b0, mk(32'h1, 32'h0, 3'b000, 1'b1), 1, 0);
        op("unk", FUN_UNK, 32'h5, 32'h5, 1'b0, mk(32'h0, 32'h0, 3'b100, 1'b1), 1, 0);
        // multiply
        op("mul_s", FUN_MUL, 32'hFFFFFFFD, 32'h7, 1'b1, mk(32'hFFFFFFEB, 32'hFFFFFFFF, 3'b001, 1'b1), 33, 32);
        op("mul_u", FUN_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h1, 32'hFFFFFFFE, 3'b010, 1'b1), 33, 32);
        op("mul_z", FUN_MUL, 32'h0, 32'hFFFFFFFB, 1'b1, mk(32'h0, 32'h0, 3'b100, 1'b1), 33, 32);
        // divide
        op("div_s", FUN_DIV, 32'hFFFFFF9C, 32'h7, 1'b1, mk(32'hFFFFFFF2, 32'hFFFFFFFE, 3'b000, 1'b0), 33, 32);
        op("div_u", FUN_DIV, 32'd100, 32'h7, 1'b0, mk(32'hE, 32'h2, 3'b000, 1'b0), 33, 32);
        op("div_sn", FUN_DIV, 32'h7, 32'hFFFFFFFE, 1'b1, mk(32'hFFFFFFFD, 32'h1, 3'b000, 1'b0), 33, 32);
        op("div_0", FUN_DIV, 32'h9, 32'h0, 1'b0, mk(32'hFFFFFFFF, 32'h9, 3'b010, 1'b0), 1, 0);
        op("div_min", FUN_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, mk(32'h80000000, 32'h0, 3'b010, 1'b0), 33, 32);
        // back-pressure: hold first result, refuse second until one retire cycle
        @(negedge clk);
        b32.iReady = 1'b0;
        send(FUN_ADD, 32'd1, 32'd2, 1'b0, mk(32'd3, 32'h0, 3'b000, 1'b1));
        b32.iA = 32'd10; b32.iB = 32'd20; b32.iValid = 1'b1;
        q.push_back(mk(32'd30, 32'h0, 3'b000, 1'b1));
        repeat (3) begin
            chk("bp.ready", 32'(b32.oReady), 32'd0);
            chk("bp.hold", b32.oS, 32'd3);
            @(negedge clk);
        end
        chk("bp.valid1", 32'(b32.oValid), 32'd1);
        cmp("bp1");
        b32.iReady = 1'b1;
        @(negedge clk);
        b32.iReady = 1'b0;
        b32.iValid = 1'b0;
        chk("bp.valid2", 32'(b32.oValid), 32'd1);
        cmp("bp2");
        repeat (2) @(negedge clk);
        chk("bp.hold2", b32.oS, 32'd30);
        b32.iReady = 1'b1;
        @(negedge clk);
        chk("bp.retired", 32'(b32.oValid), 32'd0);
        // asynchronous reset during a divide
        send(FUN_DIV, 32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 3'b000, 1'b0));
        void'(q.pop_back());
        repeat (10) @(negedge clk);
        chk("rstdiv.busy", 32'(b32.oBusy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstdiv.valid", 32'(b32.oValid), 32'd0);
        chk("rstdiv.busy0", 32'(b32.oBusy), 32'd0);
        chk("rstdiv.s", b32.oS, 32'd0);
        chk("rstdiv.hi", b32.oHi, 32'd0);
        chk("rstdiv.zvn", 32'({b32.oZ, b32.oV, b32.oN}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(b32.oValid);
        end
        chk("rstdiv.stale", seen, 0);
        op("add_after", FUN_ADD, 32'd6, 32'd7, 1'b0, mk(32'd13, 32'h0, 3'b000, 1'b1), 1, 0);
        // WIDTH=16 instance
        @(negedge clk);
        b16.iALUFun = FUN_SRA; b16.iA = 16'h4; b16.iB = 16'h8000; b16.iSign = 1'b0; b16.iValid = 1'b1;
        @(negedge clk);
        b16.iValid = 1'b0;
        chk("w16.sra.valid", 32'(b16.oValid), 32'd1);
        chk("w16.sra.s", 32'(b16.oS), 32'h0000F800);
        @(negedge clk);
        b16.iALUFun = FUN_MUL; b16.iA = 16'hFFFE; b16.iB = 16'h3; b16.iSign = 1'b1; b16.iValid = 1'b1;
        @(negedge clk);
        b16.iValid = 1'b0;
        lat = 1;
        while (!b16.oValid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("w16.mul.lat", lat, 17);
        chk("w16.mul.s", 32'(b16.oS), 32'h0000FFFA);
        chk("w16.mul.hi", 32'(b16.oHi), 32'h0000FFFF);
        chk("w16.mul.vn", 32'({b16.oV, b16.oN}), 32'd1);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
